// File: rtl/sub12u_pipe_approx.sv
// Two-stage pipelined approximate 12-bit unsigned subtractor with a truncated low borrow chain.
// Optional error monitor is built when the ERRSTAT_EN macro is defined.
module sub12u_pipe_approx #(
  parameter int unsigned APPROX_LSB = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SUM_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      A,
  input  logic [11:0]      B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      O,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [6:0]       err_max
);

  localparam int unsigned LW = 6;
  localparam int unsigned HW = 6;
  localparam int unsigned EW = 7;
  localparam int unsigned OW = 13;
  localparam logic [LW-1:0] LO_MASK = LW'((32'd1 << APPROX_LSB) - 32'd1);

  logic          s1_v_q, s1_v_d;
  logic [LW-1:0] s1_lo_q, s1_lo_d;
  logic          s1_bw_q, s1_bw_d;
  logic [HW-1:0] s1_ahi_q, s1_ahi_d;
  logic [HW-1:0] s1_bhi_q, s1_bhi_d;
  logic [LW-1:0] s1_blsb_q, s1_blsb_d;
  logic          s2_v_q, s2_v_d;
  logic [OW-1:0] o_q, o_d;
  logic [LW-1:0] s2_blsb_q, s2_blsb_d;

  logic          s2_adv_c, s1_adv_c, accept_c;
  logic [EW-1:0] mid_diff_c, hi_diff_c;

  // Low bits are masked off both operands, so the 7-bit difference carries the
  // borrow of the exact bits [5:K] only; the masked low part is then A passed through.
  always_comb begin
    s2_adv_c   = !s2_v_q || out_ready;
    s1_adv_c   = !s1_v_q || s2_adv_c;
    accept_c   = in_valid && s1_adv_c;
    mid_diff_c = {1'b0, A[5:0] & ~LO_MASK} - {1'b0, B[5:0] & ~LO_MASK};
    hi_diff_c  = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q} - EW'(s1_bw_q);

    s1_v_d    = s1_v_q;
    s1_lo_d   = s1_lo_q;
    s1_bw_d   = s1_bw_q;
    s1_ahi_d  = s1_ahi_q;
    s1_bhi_d  = s1_bhi_q;
    s1_blsb_d = s1_blsb_q;
    s2_v_d    = s2_v_q;
    o_d       = o_q;
    s2_blsb_d = s2_blsb_q;

    if (s1_adv_c) begin
      s1_v_d = in_valid;
    end
    if (accept_c) begin
      s1_lo_d   = (mid_diff_c[5:0] & ~LO_MASK) | (A[5:0] & LO_MASK);
      s1_bw_d   = mid_diff_c[6];
      s1_ahi_d  = A[11:6];
      s1_bhi_d  = B[11:6];
      s1_blsb_d = B[5:0] & LO_MASK;
    end

    if (s2_adv_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        o_d       = {hi_diff_c, s1_lo_q};
        s2_blsb_d = s1_blsb_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_lo_q   <= '0;
      s1_bw_q   <= 1'b0;
      s1_ahi_q  <= '0;
      s1_bhi_q  <= '0;
      s1_blsb_q <= '0;
      s2_v_q    <= 1'b0;
      o_q       <= '0;
      s2_blsb_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_lo_q   <= s1_lo_d;
      s1_bw_q   <= s1_bw_d;
      s1_ahi_q  <= s1_ahi_d;
      s1_bhi_q  <= s1_bhi_d;
      s1_blsb_q <= s1_blsb_d;
      s2_v_q    <= s2_v_d;
      o_q       <= o_d;
      s2_blsb_q <= s2_blsb_d;
    end
  end

  assign in_ready  = s1_adv_c;
  assign out_valid = s2_v_q;
  assign O         = o_q;

`ifdef ERRSTAT_EN
  localparam int unsigned SUM_XW = SUM_W + 1;

  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]  err_sum_q, err_sum_d;
  logic [EW-1:0]     err_max_q, err_max_d;
  logic              xfer_c;
  logic [SUM_XW-1:0] sum_ext_c;

  // The sample error equals the dropped subtrahend bits held alongside the result.
  always_comb begin
    xfer_c    = s2_v_q && out_ready;
    sum_ext_c = {1'b0, err_sum_q} + SUM_XW'(s2_blsb_q);
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      err_max_d = '0;
    end else if (xfer_c) begin
      if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      err_sum_d = sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];
      if (EW'(s2_blsb_q) > err_max_q) begin
        err_max_d = EW'(s2_blsb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
`else
  logic unused_mon;

  assign unused_mon = stat_clr ^ (^s2_blsb_q);
  assign err_cnt    = '0;
  assign err_sum    = '0;
  assign err_max    = '0;
`endif

endmodule

// File: tb/tb_sub12u_pipe_approx.sv
// Directed bench for sub12u_pipe_approx: a K=3 instance and an exact K=0 instance share stimulus.
module tb_sub12u_pipe_approx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] a, b;
  logic        out_ready;
  logic        stat_clr;
  logic        in_ready, out_valid;
  logic [12:0] o;
  logic [15:0] err_cnt;
  logic [23:0] err_sum;
  logic [6:0]  err_max;
  logic        in_ready0, out_valid0;
  logic [12:0] o0;
  logic [15:0] err_cnt0;
  logic [23:0] err_sum0;
  logic [6:0]  err_max0;

  int checks = 0;
  int errors = 0;

  sub12u_pipe_approx #(.APPROX_LSB(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .O(o),
    .stat_clr(stat_clr), .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max)
  );

  sub12u_pipe_approx #(.APPROX_LSB(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .out_valid(out_valid0), .out_ready(out_ready), .O(o0),
    .stat_clr(stat_clr), .err_cnt(err_cnt0), .err_sum(err_sum0), .err_max(err_max0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [11:0] x, input logic [11:0] y, input int k);
    logic [12:0] hi, lo;
    hi = (13'(x >> k) - 13'(y >> k)) << k;
    lo = 13'(x) & ((13'd1 << k) - 13'd1);
    return hi | lo;
  endfunction

  task automatic check_mon(input string tag, input int cnt, input int sum, input int mx, input int cnt0);
`ifdef ERRSTAT_EN
    check({tag, "_cnt"}, 32'(err_cnt), 32'(cnt));
    check({tag, "_sum"}, 32'(err_sum), 32'(sum));
    check({tag, "_max"}, 32'(err_max), 32'(mx));
    check({tag, "_cnt0"}, 32'(err_cnt0), 32'(cnt0));
`else
    check({tag, "_cnt"}, 32'(err_cnt), 32'(cnt & 0));
    check({tag, "_sum"}, 32'(err_sum), 32'(sum & 0));
    check({tag, "_max"}, 32'(err_max), 32'(mx & 0));
    check({tag, "_cnt0"}, 32'(err_cnt0), 32'(cnt0 & 0));
`endif
    check({tag, "_sum0"}, 32'(err_sum0), 32'd0);
    check({tag, "_max0"}, 32'(err_max0), 32'd0);
  endtask

  logic [12:0] exp_q[$];
  logic [12:0] exp0_q[$];
  logic [12:0] e, e0;
  int ndeliv, sum_exp, max_exp, lsb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; stat_clr = 1'b0;
    step(); step();
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    check_mon("rst", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    // basic: 100 - 37 with three truncated bits
    a = 12'd100; b = 12'd37; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_lat1", 32'(out_valid), 32'd0);
    step();
    check("basic_ov", 32'(out_valid), 32'd1);
    check("basic_o", 32'(o), 32'd68);
    check("basic_o_exact", 32'(o0), 32'd63);
    step();
    check("basic_ov_done", 32'(out_valid), 32'd0);
    check_mon("basic", 1, 5, 5, 1);

    // wrap cases streamed back to back
    a = 12'd0; b = 12'd4095; in_valid = 1'b1;
    step();
    a = 12'd5; b = 12'd7;
    step();
    in_valid = 1'b0;
    check("wrap_o", 32'(o), 32'h1008);
    check("wrap_o_exact", 32'(o0), 32'h1001);
    step();
    check("wrap2_o", 32'(o), 32'd5);
    check("wrap2_o_exact", 32'(o0), 32'h1ffe);
    step();
    check("wrap_ov_done", 32'(out_valid), 32'd0);
    check_mon("wrap", 3, 19, 7, 3);

    // backpressure: pipeline fills to two entries then stalls
    out_ready = 1'b0;
    a = 12'h7f8; b = 12'h7f8; in_valid = 1'b1;
    step();
    check("bp_rdy1", 32'(in_ready), 32'd1);
    a = 12'h123; b = 12'h123;
    step();
    check("bp_rdy_drop", 32'(in_ready), 32'd0);
    check("bp_ov", 32'(out_valid), 32'd1);
    check("bp_o_eq", 32'(o), 32'd0);
    check("bp_o_eq_exact", 32'(o0), 32'd0);
    a = 12'd2000; b = 12'd1000;
    step();
    check("bp_o_stable", 32'(o), 32'd0);
    check("bp_ov_stable", 32'(out_valid), 32'd1);
    check("bp_rdy_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_comb", 32'(in_ready), 32'd1);
    step();
    check("bp_p1_o", 32'(o), 32'd3);
    check("bp_p1_o_exact", 32'(o0), 32'd0);
    a = 12'd4095; b = 12'd0;
    step();
    in_valid = 1'b0;
    check("bp_p2_o", 32'(o), 32'd1000);
    check("bp_p2_o_exact", 32'(o0), 32'd1000);
    step();
    check("bp_p3_o", 32'(o), 32'd4095);
    check("bp_p3_ov", 32'(out_valid), 32'd1);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // full-rate random traffic after a monitor clear
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check_mon("clr", 0, 0, 0, 0);
    ndeliv = 0; sum_exp = 0; max_exp = 0;
    for (int i = 0; i < 104; i++) begin
      if (i < 100) begin
        a = 12'($urandom); b = 12'($urandom); in_valid = 1'b1;
        check("fr_rdy", 32'(in_ready), 32'd1);
        exp_q.push_back(model(a, b, 3));
        exp0_q.push_back(12'(a) - 13'(b));
        lsb = int'(b & 12'd7);
        sum_exp += lsb;
        if (lsb > max_exp) max_exp = lsb;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("fr_ov", 32'(out_valid), 32'((i >= 1) && (i <= 100)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("fr_extra", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          e0 = exp0_q.pop_front();
          check("fr_o", 32'(o), 32'(e));
          check("fr_o_exact", 32'(o0), 32'(e0));
          ndeliv++;
        end
      end
    end
    check("fr_count", 32'(ndeliv), 32'd100);
    check_mon("fr", 100, sum_exp, max_exp, 100);

    // clear coincident with a transfer drops the sample
    a = 12'd1; b = 12'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_ov", 32'(out_valid), 32'd1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check_mon("clr_xfer", 0, 0, 0, 0);

    // reset with both stages occupied
    out_ready = 1'b0;
    a = 12'd9; b = 12'd1; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    check("mid_ov_full", 32'(out_valid), 32'd1);
    check("mid_rdy_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_o", 32'(o), 32'd0);
    check_mon("mid_rst", 0, 0, 0, 0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
